// File: rtl/wb_adc_scanner.sv
// Wishbone-controlled multi-channel ADC scanner.
// Walks the enabled channels, converts each and keeps the last sample per channel.
module wb_adc_scanner #(
  parameter int CLK_DIV_DEFAULT = 50,
  parameter int OEC_TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic [7:0]  adc_data,
  input  logic        adc_oec,
  output logic        adc_clk,
  output logic        adc_start,
  output logic [2:0]  adc_sel,
  output logic        intr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CAPT   = 3'd4;

  logic        ack_q;
  logic [31:0] dat_q, rd_dat;
  logic        run_q, run_d;
  logic        cont_q, cont_d;
  logic        irqen_q, irqen_d;
  logic [7:0]  mask_q, mask_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic [15:0] div_q, div_d;
  logic [7:0][8:0] res_q, res_d;
  logic [2:0]  state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  smp_q, smp_d;
  logic [15:0] ccnt_q;
  logic        aclk_q;
  logic [2:0]  sync_q;

  logic [3:0]  ra;
  logic        req, wr, busy, oec_rise;
  logic        wr_ctrl, wr_mask, wr_stat, wr_div0, wr_div1;
  logic        done_set, tmo_set;
  logic [15:0] div_eff;
  logic [31:0] start_last;
  logic [3:0]  nxt;
  logic        unused;

  assign unused = ^{wb_adr_i[31:6], wb_adr_i[1:0],
                    wb_dat_i[31:16], wb_sel_i[3:2]};

  assign ra      = wb_adr_i[5:2];
  assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = req & wb_we_i;
  assign wr_ctrl = wr & (ra == 4'd0) & wb_sel_i[0];
  assign wr_mask = wr & (ra == 4'd1) & wb_sel_i[0];
  assign wr_stat = wr & (ra == 4'd2) & wb_sel_i[0];
  assign wr_div0 = wr & (ra == 4'd3) & wb_sel_i[0];
  assign wr_div1 = wr & (ra == 4'd3) & wb_sel_i[1];

  assign busy       = (state_q != S_IDLE);
  assign oec_rise   = sync_q[1] & ~sync_q[2];
  assign div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
  assign start_last = {15'd0, div_eff, 1'b0} - 32'd1;

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign adc_clk   = aclk_q;
  assign adc_start = (state_q == S_START);
  assign adc_sel   = ch_q;
  assign intr      = irqen_q & (done_q | tmo_q);

  // Lowest set mask bit at or above lo; bit 3 flags a hit.
  function automatic logic [3:0] pick(
    input logic [7:0] m,
    input int         lo
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    rd_dat = 32'd0;
    unique case (1'b1)
      (ra == 4'd0): rd_dat[2:0] = {irqen_q, cont_q, run_q};
      (ra == 4'd1): rd_dat[7:0] = mask_q;
      (ra == 4'd2): rd_dat[6:0] = {ch_q, 1'b0, tmo_q, done_q, busy};
      (ra == 4'd3): rd_dat[15:0] = div_q;
      ra[3]:        rd_dat[8:0] = res_q[ra[2:0]];
      default:      rd_dat = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tmr_d    = tmr_q;
    smp_d    = smp_q;
    run_d    = run_q;
    cont_d   = cont_q;
    irqen_d  = irqen_q;
    mask_d   = mask_q;
    div_d    = div_q;
    res_d    = res_q;
    done_set = 1'b0;
    tmo_set  = 1'b0;
    nxt      = 4'd0;

    if (wr_ctrl) begin
      run_d   = wb_dat_i[0];
      cont_d  = wb_dat_i[1];
      irqen_d = wb_dat_i[2];
    end
    if (wr_mask) mask_d = wb_dat_i[7:0];
    if (wr_div0) div_d[7:0] = wb_dat_i[7:0];
    if (wr_div1) div_d[15:8] = wb_dat_i[15:8];

    unique case (state_q)
      S_IDLE: begin
        if (wr_ctrl && wb_dat_i[0]) begin
          nxt = pick(mask_q, 0);
          if (nxt[3]) begin
            state_d = S_SELECT;
            ch_d    = nxt[2:0];
            tmr_d   = 32'd0;
          end else begin
            done_set = 1'b1;
            run_d    = 1'b0;
          end
        end
      end
      S_SELECT: begin
        if (tmr_q == 32'd3) begin
          state_d = S_START;
          tmr_d   = 32'd0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_START: begin
        if (tmr_q >= start_last) begin
          state_d = S_WAIT;
          tmr_d   = 32'd0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (oec_rise) begin
          smp_d   = adc_data;
          state_d = S_CAPT;
        end else if (tmr_q >= 32'(OEC_TIMEOUT - 1)) begin
          smp_d   = 8'h00;
          tmo_set = 1'b1;
          state_d = S_CAPT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_CAPT: begin
        res_d[ch_q] = {1'b1, smp_q};
        tmr_d       = 32'd0;
        nxt         = pick(mask_q, int'(ch_q) + 1);
        if (nxt[3]) begin
          state_d = S_SELECT;
          ch_d    = nxt[2:0];
        end else begin
          done_set = 1'b1;
          nxt      = pick(mask_q, 0);
          if (run_q && cont_q && nxt[3]) begin
            state_d = S_SELECT;
            ch_d    = nxt[2:0];
          end else begin
            state_d = S_IDLE;
            run_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stop request wins over whatever the scan was doing.
    if (busy && wr_ctrl && !wb_dat_i[0]) begin
      state_d  = S_IDLE;
      res_d    = res_q;
      done_set = 1'b0;
      tmo_set  = 1'b0;
      run_d    = 1'b0;
    end

    done_d = (done_q & ~(wr_stat & wb_dat_i[1])) | done_set;
    tmo_d  = (tmo_q & ~(wr_stat & wb_dat_i[2])) | tmo_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      run_q   <= 1'b0;
      cont_q  <= 1'b0;
      irqen_q <= 1'b0;
      mask_q  <= 8'hFF;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      div_q   <= 16'(CLK_DIV_DEFAULT);
      res_q   <= '0;
      state_q <= S_IDLE;
      ch_q    <= 3'd0;
      tmr_q   <= 32'd0;
      smp_q   <= 8'd0;
    end else begin
      ack_q   <= req;
      dat_q   <= (req && !wb_we_i) ? rd_dat : 32'd0;
      run_q   <= run_d;
      cont_q  <= cont_d;
      irqen_q <= irqen_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      div_q   <= div_d;
      res_q   <= res_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      tmr_q   <= tmr_d;
      smp_q   <= smp_d;
    end
  end

  // Free-running divider; >= keeps it sane when DIV shrinks mid-count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ccnt_q <= 16'd0;
      aclk_q <= 1'b0;
    end else if (ccnt_q >= div_eff - 16'd1) begin
      ccnt_q <= 16'd0;
      aclk_q <= ~aclk_q;
    end else begin
      ccnt_q <= ccnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 3'd0;
    else       sync_q <= {sync_q[1:0], adc_oec};
  end

endmodule

// File: tb/tb_wb_adc_scanner.sv
// Directed bench for wb_adc_scanner with a simple ADC responder.
module tb_wb_adc_scanner;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_MASK = 32'h04;
  localparam logic [31:0] A_STAT = 32'h08;
  localparam logic [31:0] A_DIV  = 32'h0C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_ack_o;
  logic [7:0]  adc_data = '0;
  logic        adc_oec = 1'b0;
  logic        adc_clk;
  logic        adc_start;
  logic [2:0]  adc_sel;
  logic        intr;

  int nvec = 0;
  int nmis = 0;
  int n_start = 0;
  bit oec_en = 1'b0;
  logic [7:0] model_data [8];

  wb_adc_scanner dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .adc_data(adc_data), .adc_oec(adc_oec),
    .adc_clk(adc_clk), .adc_start(adc_start),
    .adc_sel(adc_sel), .intr(intr)
  );

  always #5 clk = ~clk;

  always @(posedge adc_start) n_start++;

  // ADC responder: answer a few clocks after each start pulse.
  always begin
    logic [2:0] ch;
    @(negedge adc_start);
    ch = adc_sel;
    if (oec_en) begin
      repeat (3) @(posedge clk);
      #2;
      adc_data = model_data[ch];
      adc_oec = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      adc_oec = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s,
                         input logic we,
                         output logic [31:0] q);
    bit got;
    got = 1'b0;
    q = '0;
    @(negedge clk);
    wb_adr_i = a;
    wb_dat_i = d;
    wb_sel_i = s;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o) begin
        got = 1'b1;
        q = wb_dat_o;
        break;
      end
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!got) chk("wb_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_wr(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s);
    logic [31:0] q;
    wb_xfer(a, d, s, 1'b1, q);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] m,
                        input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(a, '0, 4'hF, 1'b0, q);
    chk(tag, q & m, exp);
  endtask

  task automatic wait_stat(input string tag,
                           input logic [31:0] m,
                           input logic [31:0] v,
                           input int polls);
    logic [31:0] q;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < polls; i++) begin
      wb_xfer(A_STAT, '0, 4'hF, 1'b0, q);
      if ((q & m) == v) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_start(input string tag, input bit lvl);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (adc_start == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic toggles(input string tag,
                         input int n,
                         input int exp);
    int c;
    logic p;
    c = 0;
    p = adc_clk;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (adc_clk != p) c++;
      p = adc_clk;
    end
    chk(tag, 32'(c), 32'(exp));
  endtask

  initial begin
    int s0;
    model_data[0] = 8'h3C;
    model_data[2] = 8'hA5;
    model_data[7] = 8'h5A;

    // Reset values
    #12;
    chk("rst_ack", 32'(wb_ack_o), 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_aclk", 32'(adc_clk), 0);
    chk("rst_start", 32'(adc_start), 0);
    chk("rst_sel", 32'(adc_sel), 0);
    chk("rst_intr", 32'(intr), 0);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("rst_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_mask", A_MASK, 32'hFFFF_FFFF, 32'hFF);
    rd_chk("rst_stat", A_STAT, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_div", A_DIV, 32'hFFFF_FFFF, 32'd50);
    rd_chk("rst_res3", 32'h2C, 32'hFFFF_FFFF, 32'h0);
    rd_chk("unmapped", 32'h10, 32'hFFFF_FFFF, 32'h0);

    // Byte lanes and DIV=0 behaving as 1
    wb_wr(A_DIV, 32'h0000_0302, 4'b0010);
    rd_chk("div_lane1", A_DIV, 32'hFFFF, 32'h0300 | 32'd50);
    wb_wr(A_DIV, 32'h0, 4'b0011);
    toggles("aclk_div0", 20, 20);
    wb_wr(A_DIV, 32'h2, 4'b0011);
    toggles("aclk_div2", 40, 20);

    // RUN with empty mask
    wb_wr(A_MASK, 32'h05, 4'b0000);
    rd_chk("mask_nosel", A_MASK, 32'hFF, 32'hFF);
    wb_wr(A_MASK, 32'h00, 4'b0001);
    s0 = n_start;
    wb_wr(A_CTRL, 32'h1, 4'b0001);
    rd_chk("m0_stat", A_STAT, 32'hFFFF_FFFF, 32'h2);
    rd_chk("m0_ctrl", A_CTRL, 32'h7, 32'h0);
    repeat (10) @(posedge clk);
    chk("m0_nostart", 32'(n_start - s0), 0);
    wb_wr(A_STAT, 32'h2, 4'b0001);
    rd_chk("m0_w1c", A_STAT, 32'h7, 32'h0);

    // Two-channel single scan
    oec_en = 1'b1;
    wb_wr(A_MASK, 32'h05, 4'b0001);
    s0 = n_start;
    wb_wr(A_CTRL, 32'h1, 4'b0001);
    wait_stat("s1_idle", 32'h1, 32'h0, 100);
    rd_chk("s1_res0", 32'h20, 32'h1FF, 32'h13C);
    rd_chk("s1_res1", 32'h24, 32'h1FF, 32'h000);
    rd_chk("s1_res2", 32'h28, 32'h1FF, 32'h1A5);
    rd_chk("s1_stat", A_STAT, 32'h7, 32'h2);
    rd_chk("s1_ctrl", A_CTRL, 32'h7, 32'h0);
    chk("s1_starts", 32'(n_start - s0), 2);
    chk("s1_intr", 32'(intr), 0);
    rd_chk("s1_res0_again", 32'h20, 32'h1FF, 32'h13C);
    wb_wr(A_STAT, 32'h2, 4'b0001);

    // Timeout
    oec_en = 1'b0;
    wb_wr(A_MASK, 32'h01, 4'b0001);
    wb_wr(A_CTRL, 32'h1, 4'b0001);
    wait_stat("to_idle", 32'h1, 32'h0, 800);
    rd_chk("to_res0", 32'h20, 32'h1FF, 32'h100);
    rd_chk("to_stat", A_STAT, 32'h7, 32'h6);
    wb_wr(A_STAT, 32'h6, 4'b0001);
    rd_chk("to_w1c", A_STAT, 32'h7, 32'h0);

    // Continuous scan on channel 7 with interrupt
    oec_en = 1'b1;
    wb_wr(A_MASK, 32'h80, 4'b0001);
    wb_wr(A_CTRL, 32'h7, 4'b0001);
    wait_stat("c_done", 32'h2, 32'h2, 100);
    chk("c_intr", 32'(intr), 1);
    rd_chk("c_res7", 32'h3C, 32'h1FF, 32'h15A);
    rd_chk("c_busy", A_STAT, 32'h71, 32'h71);
    wait_start("c_start", 1'b1);
    wb_wr(A_STAT, 32'h2, 4'b0001);
    chk("c_intr_clr", 32'(intr), 0);
    wait_stat("c_done2", 32'h2, 32'h2, 60);
    chk("c_intr2", 32'(intr), 1);
    wb_wr(A_CTRL, 32'h0, 4'b0001);
    rd_chk("c_stop", A_STAT, 32'h1, 32'h0);
    wb_wr(A_STAT, 32'h6, 4'b0001);
    repeat (15) @(posedge clk);

    // Abort during START
    model_data[7] = 8'h11;
    wb_wr(A_CTRL, 32'h1, 4'b0001);
    wait_start("ab_start", 1'b1);
    wb_wr(A_CTRL, 32'h0, 4'b0001);
    chk("ab_start0", 32'(adc_start), 0);
    rd_chk("ab_busy", A_STAT, 32'h1, 32'h0);
    rd_chk("ab_res7", 32'h3C, 32'h1FF, 32'h15A);
    repeat (15) @(posedge clk);
    oec_en = 1'b0;

    // Reset during WAIT
    wb_wr(A_MASK, 32'h01, 4'b0001);
    wb_wr(A_DIV, 32'h3, 4'b0011);
    wb_wr(A_CTRL, 32'h5, 4'b0001);
    wait_start("rw_start", 1'b1);
    wait_start("rw_wait", 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rw_start0", 32'(adc_start), 0);
    chk("rw_sel", 32'(adc_sel), 0);
    chk("rw_aclk", 32'(adc_clk), 0);
    chk("rw_intr", 32'(intr), 0);
    chk("rw_ack", 32'(wb_ack_o), 0);
    chk("rw_dat", wb_dat_o, 0);
    @(negedge clk);
    reset = 1'b0;
    s0 = n_start;
    repeat (30) @(posedge clk);
    chk("rw_nostart", 32'(n_start - s0), 0);
    rd_chk("rw_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rw_mask", A_MASK, 32'hFFFF_FFFF, 32'hFF);
    rd_chk("rw_stat", A_STAT, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rw_div", A_DIV, 32'hFFFF_FFFF, 32'd50);
    rd_chk("rw_res0", 32'h20, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rw_res7", 32'h3C, 32'hFFFF_FFFF, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/wb_adc_scanner.md
WB_ADC_SCANNER -- requirements
Module: wb_adc_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV_DEFAULT, default 50, giving the reset value of DIV (clk cycles per adc_clk half-period).
REQ-002 SHALL have parameter OEC_TIMEOUT, default 1024, giving the maximum clk cycles to wait for adc_oec.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port wb_adr_i, input, 32 bits: Wishbone address; only bits [5:2] are decoded.
REQ-006 SHALL have port wb_dat_i, input, 32 bits: Wishbone write data.
REQ-007 SHALL have port wb_dat_o, output, 32 bits: Wishbone read data.
REQ-008 SHALL have ports wb_stb_i, wb_cyc_i and wb_we_i, each input, 1 bit: Wishbone strobe, cycle and write-enable.
REQ-009 SHALL have port wb_sel_i, input, 4 bits: byte lane enables.
REQ-010 SHALL have port wb_ack_o, output, 1 bit: Wishbone acknowledge.
REQ-011 SHALL have port adc_data, input, 8 bits: converted ADC sample.
REQ-012 SHALL have port adc_oec, input, 1 bit: asynchronous ADC end-of-conversion flag, high when adc_data is valid.
REQ-013 SHALL have ports adc_clk, adc_start and adc_sel, outputs of 1, 1 and 3 bits: ADC clock, start-of-conversion pulse and channel select.
REQ-014 SHALL have port intr, output, 1 bit: level interrupt.

Function
REQ-015 SHALL decode registers by wb_adr_i[5:2]:
- 0 CTRL (RW): bit0 RUN, bit1 CONT, bit2 IRQEN.
- 1 MASK (RW): bits [7:0], one enable per channel.
- 2 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 TMO (W1C); bits [6:4] hold the current channel (RO).
- 3 DIV (RW): bits [15:0].
- 8..15 RESULT0..7 (RO): bits [7:0] hold the last sample, bit8 is VALID.
- All other addresses read as 0.
REQ-016 SHALL assert wb_ack_o for exactly one clk, in the cycle after a clk where wb_stb_i & wb_cyc_i & ~wb_ack_o is true; the write takes effect at the same edge that raises wb_ack_o.
REQ-017 SHALL apply writes to a byte only when the matching wb_sel_i bit is 1.
REQ-018 SHALL treat a DIV value of 0 as 1.
REQ-019 SHALL generate adc_clk from a free-running counter that toggles adc_clk each time the counter has counted DIV clk cycles.
REQ-020 SHALL pass adc_oec through a 2-flop synchronizer and detect its rising edge.
REQ-021 SHALL implement an FSM with states IDLE, SELECT, START, WAIT, CAPTURE, and transitions as follows:
- IDLE -> SELECT when RUN is written 1 while MASK != 0; the FSM loads the lowest set mask bit as the current channel.
- SELECT: adc_sel = current channel; stays 4 clk, then -> START.
- START: adc_start = 1 for 2*DIV clk, then -> WAIT.
- WAIT -> CAPTURE on the synchronized rising edge of adc_oec.
- WAIT -> CAPTURE with TMO set and the sample forced to 0x00 after OEC_TIMEOUT clk without that edge.
- CAPTURE (1 clk): RESULT[ch] = {VALID=1, sample}; then the FSM advances to the next higher set mask bit -> SELECT.
REQ-022 SHALL treat a CAPTURE with no higher set mask bit as end of scan:
- DONE is set.
- If CONT=1 and RUN=1, the FSM -> SELECT at the lowest set bit.
- Otherwise RUN is cleared and the FSM -> IDLE.
REQ-023 SHALL, when RUN is written 1 with MASK=0, set DONE in the same cycle, clear RUN and start no conversion.
REQ-024 SHALL, when RUN is written 0 in any non-IDLE state, drop adc_start in the next clk, go to IDLE and leave RESULT unchanged.
REQ-025 SHALL sample MASK only when choosing the next channel; a MASK write mid-scan affects subsequent selections only.
REQ-026 SHALL give DONE priority if a W1C write and a DONE set occur in the same clk.
REQ-027 SHALL drive BUSY = (state != IDLE).
REQ-028 SHALL drive intr = IRQEN & (DONE | TMO).
REQ-029 SHALL NOT clear VALID bits on a read.

Reset
REQ-030 SHALL on reset asynchronously:
- set the state to IDLE;
- set CTRL=0, MASK=0xFF, DIV=CLK_DIV_DEFAULT, STATUS=0 and all RESULT=0;
- drive wb_ack_o=0, wb_dat_o=0, adc_clk=0, adc_start=0, adc_sel=0 and intr=0;
- clear the synchronizer and counters.
REQ-031 SHALL abort any conversion when reset is asserted mid-scan, and SHALL NOT start a conversion after deassertion until RUN is written.

Verification
REQ-032 SHALL pass this scenario: MASK=0x05, DIV=2, CTRL=0x1, and the model raises adc_oec with data 0x3C (channel 0), then 0xA5 (channel 2) -> RESULT0=0x13C, RESULT2=0x1A5, RESULT1=0, DONE=1, RUN=0.
REQ-033 SHALL pass this scenario: CTRL=0x7, MASK=0x80 -> channel 7 is converted repeatedly, DONE sets after the first capture, intr=1; writing STATUS=0x2 drops intr for at most one scan.
REQ-034 SHALL pass this scenario: adc_oec held low, MASK=0x01, RUN=1 -> after OEC_TIMEOUT clk, TMO=1 and RESULT0=0x100.
REQ-035 SHALL pass this scenario: CTRL=0x1 with MASK=0 -> DONE=1 and adc_start never pulses.
REQ-036 SHALL pass this scenario: RUN is cleared during START -> adc_start=0 next clk, BUSY=0, RESULT unchanged.
REQ-037 SHALL pass this scenario: reset is asserted during WAIT -> all outputs and registers return to the REQ-030 values, and adc_start stays 0 after release.
